// File: rtl/mem_access_sequencer_pkg.sv
// Shared definitions for the MEM-stage access sequencer.
//   - access-size encodings (size_e)
//   - FSM state encodings (state_e)
//   - latched request fields (req_t)
//   - lane_mask(): byte-lane mask of an access across a two-word (8-lane) window
package mem_access_sequencer_pkg;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 8;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10,
        SIZE_X = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LO   = 3'd1,
        S_HI   = 3'd2,
        S_RESP = 3'd3,
        S_ERR  = 3'd4
    } state_e;

    typedef struct packed {
        size_e       size;
        logic        we;
        logic        is_unsigned;
        logic [31:0] wdata;
    } req_t;

    // Bits [3:0] are lanes of the addressed word, bits [7:4] lanes of the next
    // word. The illegal size yields an empty mask; such requests never reach
    // a memory cycle anyway.
    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [7:0] base;
        case (size)
            SIZE_B:  base = 8'h01;
            SIZE_H:  base = 8'h03;
            SIZE_W:  base = 8'h0F;
            default: base = 8'h00;
        endcase
        return base << off;
    endfunction

endpackage

// File: rtl/mem_access_sequencer_load_align_extend.sv
// load_align_extend: purely combinational load-result formatter.
//   r64         in  64  read data window (hi word : lo word, or 0 : word)
//   off         in  2   byte offset of the access within the first word
//   size        in  2   access size encoding
//   is_unsigned in  1   1 zero-extend, 0 sign-extend
//   result      out 32  aligned and extended load value
module load_align_extend
    import mem_access_sequencer_pkg::*;
(
    input  logic [63:0] r64,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic [31:0] sh;

    // Bring the first addressed byte down to lane 0.
    assign sh = 32'(r64 >> {off, 3'b000});

    always_comb begin
        result = '0;
        case (size)
            SIZE_B:  result = {{24{~is_unsigned & sh[7]}}, sh[7:0]};
            SIZE_H:  result = {{16{~is_unsigned & sh[15]}}, sh[15:0]};
            SIZE_W:  result = sh;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: MEM-stage controller for a byte-enabled word memory.
// Accepts one load/store per request, drives one memory cycle (or two for a
// word-crossing access), then pulses a one-cycle response.
//   clk, reset              clock, synchronous active-high reset
//   req_valid/req_ready     request handshake; ready only while idle
//   req_addr/size/we/
//   req_unsigned/req_wdata  request fields, latched at accept
//   resp_valid/err/rdata    completion pulse, error flag, load result
//   mem_addr/be/we/re/wdata word-memory command
//   mem_rdata               read data, valid the cycle after mem_re
module mem_access_sequencer
    import mem_access_sequencer_pkg::*;
#(
    parameter bit ALLOW_MISALIGNED = 1'b1,
    parameter int ADDR_W           = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_we,
    input  logic              req_unsigned,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic              mem_we,
    output logic              mem_re,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [ADDR_W-3:0] WORD_ONE = 1;

    state_e            state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    req_t              req_q;
    logic [31:0]       lo_buf;

    logic [1:0]        off;
    logic [7:0]        mask8;
    logic              split;
    logic [63:0]       w64;
    logic [ADDR_W-3:0] word_a, word_b;
    logic              in_split, in_reject;
    logic [63:0]       r64;
    logic [31:0]       ld_result;

    // Lane math on the latched request.
    assign off    = addr_q[1:0];
    assign mask8  = lane_mask(req_q.size, off);
    assign split  = |mask8[7:4];
    assign w64    = {32'b0, req_q.wdata} << {off, 3'b000};
    assign word_a = addr_q[ADDR_W-1:2];
    assign word_b = word_a + WORD_ONE;   // wraps at the top of the word space

    // Accept-time decision uses the live request, since it is latched on the same edge.
    assign in_split  = lane_mask(req_size, req_addr[1:0]) > 8'h0F;
    assign in_reject = (req_size == SIZE_X) || (in_split && !ALLOW_MISALIGNED);

    // In RESP, mem_rdata holds the last word read: the only word, or the HI word.
    assign r64 = split ? {mem_rdata, lo_buf} : {32'b0, mem_rdata};

    load_align_extend u_lae (
        .r64         (r64),
        .off         (off),
        .size        (req_q.size),
        .is_unsigned (req_q.is_unsigned),
        .result      (ld_result)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
            req_q  <= '0;
            lo_buf <= '0;
        end else begin
            if (state == S_IDLE && req_valid) begin
                addr_q            <= req_addr;
                req_q.size        <= size_e'(req_size);
                req_q.we          <= req_we;
                req_q.is_unsigned <= req_unsigned;
                req_q.wdata       <= req_wdata;
            end
            // LO word read data arrives during HI.
            if (state == S_HI) lo_buf <= mem_rdata;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (req_valid) state_nxt = in_reject ? S_ERR : S_LO;
            S_LO:    state_nxt = split ? S_HI : S_RESP;
            S_HI:    state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        mem_addr   = '0;
        mem_be     = '0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_wdata  = '0;
        case (state)
            S_IDLE: req_ready = 1'b1;
            S_LO: begin
                mem_addr  = word_a;
                mem_be    = mask8[3:0];
                mem_we    = req_q.we;
                mem_re    = ~req_q.we;
                mem_wdata = w64[31:0];
            end
            S_HI: begin
                mem_addr  = word_b;
                mem_be    = mask8[7:4];
                mem_we    = req_q.we;
                mem_re    = ~req_q.we;
                mem_wdata = w64[63:32];
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_rdata = req_q.we ? 32'b0 : ld_result;
            end
            S_ERR: begin
                resp_valid = 1'b1;
                resp_err   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
module tb_mem_access_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic        mem_we, mem_re;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    // second instance with misaligned accesses rejected
    logic        valid2, ready2, resp_valid2, resp_err2, mem_we2, mem_re2;
    logic [31:0] resp_rdata2, mem_wdata2;
    logic [29:0] mem_addr2;
    logic [3:0]  mem_be2;
    logic [31:0] zero32 = '0;

    always #5 clk = ~clk;

    mem_access_sequencer #(.ALLOW_MISALIGNED(1'b1), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_size(req_size), .req_we(req_we),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_we(mem_we), .mem_re(mem_re),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

    mem_access_sequencer #(.ALLOW_MISALIGNED(1'b0), .ADDR_W(32)) dut2 (
        .clk(clk), .reset(reset), .req_valid(valid2), .req_ready(ready2),
        .req_addr(req_addr), .req_size(req_size), .req_we(req_we),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .resp_valid(resp_valid2), .resp_err(resp_err2), .resp_rdata(resp_rdata2),
        .mem_addr(mem_addr2), .mem_be(mem_be2), .mem_we(mem_we2), .mem_re(mem_re2),
        .mem_wdata(mem_wdata2), .mem_rdata(zero32));

    typedef struct packed {
        logic        rdy, rv, err;
        logic [31:0] rdata;
        logic [29:0] maddr;
        logic [3:0]  be;
        logic        we, re;
        logic [31:0] wdata;
    } obs_t;

    typedef struct packed {
        logic [29:0] a;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wd;
    } mlog_t;

    obs_t        exp_q[$];
    mlog_t       mlog[$];
    int          checks = 0, passes = 0, cyc = 0, acc_cyc = 0, acc_cnt = 0, last_lat = 0;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;

    // Memory window: 1 KiB, byte address bits [9:0]. Regions used by the
    // tests (0x000, 0x100, 0x200, 0x3FC) do not alias.
    logic [7:0] mockm [0:1023] = '{default: 8'h00};
    logic [7:0] refm  [0:1023] = '{default: 8'h00};

    function automatic logic [9:0] bidx(input logic [31:0] a);
        return a[9:0];
    endfunction

    function automatic logic [9:0] lane_idx(input logic [29:0] w, input int l);
        logic [31:0] b;
        b = {w, 2'b00} + 32'(l);
        return b[9:0];
    endfunction

    // Word memory with 1-cycle synchronous read.
    always @(posedge clk) begin
        if (mem_re)
            mem_rdata <= {mockm[lane_idx(mem_addr, 3)], mockm[lane_idx(mem_addr, 2)],
                          mockm[lane_idx(mem_addr, 1)], mockm[lane_idx(mem_addr, 0)]};
        if (mem_we)
            for (int l = 0; l < 4; l++)
                if (mem_be[l]) mockm[lane_idx(mem_addr, l)] <= mem_wdata[8*l +: 8];
    end

    function automatic obs_t idle_obs();
        obs_t o;
        o = '0;
        o.rdy = 1'b1;
        return o;
    endfunction

    // Reference: walk the accessed bytes one by one, group them by word,
    // and produce the expected per-cycle outputs following the accept edge.
    task automatic model_req(input logic [31:0] a, input logic [1:0] sz, input logic we,
                             input logic uns, input logic [31:0] wd);
        obs_t        e;
        int          n;
        logic [29:0] w0, w1;
        logic [3:0]  be0, be1;
        logic [31:0] wd0, wd1, v, b;
        logic        two;
        if (sz == 2'b11) begin
            e = '0; e.rv = 1'b1; e.err = 1'b1;
            exp_q.push_back(e);
            return;
        end
        n = 1 << sz;
        w0 = a[31:2]; w1 = w0 + 30'd1;
        be0 = '0; be1 = '0; wd0 = '0; wd1 = '0; v = '0; two = 1'b0;
        for (int i = 0; i < n; i++) begin
            b = a + 32'(i);
            if (b[31:2] == w0) begin
                be0[b[1:0]] = 1'b1;
                wd0[8*b[1:0] +: 8] = wd[8*i +: 8];
            end else begin
                two = 1'b1;
                be1[b[1:0]] = 1'b1;
                wd1[8*b[1:0] +: 8] = wd[8*i +: 8];
            end
            v[8*i +: 8] = refm[bidx(b)];
            if (we) refm[bidx(b)] = wd[8*i +: 8];
        end
        if (!uns && n < 4 && v[8*n-1])
            for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
        e = '0; e.maddr = w0; e.be = be0; e.we = we; e.re = !we; e.wdata = wd0;
        exp_q.push_back(e);
        if (two) begin
            e = '0; e.maddr = w1; e.be = be1; e.we = we; e.re = !we; e.wdata = wd1;
            exp_q.push_back(e);
        end
        e = '0; e.rv = 1'b1; e.rdata = we ? 32'b0 : v;
        exp_q.push_back(e);
    endtask

    // Per-cycle compare of every output of the main instance against the model.
    initial begin
        obs_t o, e;
        forever begin
            @(posedge clk);
            cyc++;
            if (req_valid && req_ready && !reset) begin
                acc_cyc = cyc;
                acc_cnt++;
            end
            #1;
            o = '{rdy: req_ready, rv: resp_valid, err: resp_err, rdata: resp_rdata,
                  maddr: mem_addr, be: mem_be, we: mem_we, re: mem_re, wdata: mem_wdata};
            e = (exp_q.size() > 0) ? exp_q.pop_front() : idle_obs();
            checks++;
            if (o === e) passes++;
            else $display("FAIL cycle%0d outputs: got rdy=%b rv=%b err=%b rdata=%h addr=%h be=%b we=%b re=%b wdata=%h; want rdy=%b rv=%b err=%b rdata=%h addr=%h be=%b we=%b re=%b wdata=%h",
                          cyc, o.rdy, o.rv, o.err, o.rdata, o.maddr, o.be, o.we, o.re, o.wdata,
                          e.rdy, e.rv, e.err, e.rdata, e.maddr, e.be, e.we, e.re, e.wdata);
            if (mem_we || mem_re) mlog.push_back('{a: mem_addr, be: mem_be, we: mem_we, wd: mem_wdata});
            if (resp_valid) begin
                last_rdata = resp_rdata;
                last_err   = resp_err;
                last_lat   = cyc - acc_cyc + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            $display("FAIL drain timeout: %0d expected cycles left, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_req(input logic [31:0] a, input logic [1:0] sz, input logic we,
                          input logic uns, input logic [31:0] wd);
        @(negedge clk);
        mlog.delete();
        req_addr = a; req_size = sz; req_we = we; req_unsigned = uns; req_wdata = wd;
        req_valid = 1'b1;
        model_req(a, sz, we, uns, wd);
        @(negedge clk);
        req_valid = 1'b0;
        drain();
    endtask

    initial begin
        int acc0;
        req_valid = 0; valid2 = 0; req_addr = 0; req_size = 0; req_we = 0;
        req_unsigned = 0; req_wdata = 0;
        repeat (2) @(negedge clk);
        chk("reset ready", {31'b0, req_ready}, 1);
        chk("reset resp_valid", {31'b0, resp_valid}, 0);
        chk("reset strobes", {26'b0, mem_we, mem_re, mem_be}, 0);
        reset = 1'b0;

        // sw 0x100
        do_req(32'h100, 2'b10, 1, 0, 32'hDEADBEEF);
        chk("sw cycles", mlog.size(), 1);
        chk("sw addr", {2'b0, mlog[0].a}, 32'h40);
        chk("sw be", {28'b0, mlog[0].be}, 32'hF);
        chk("sw wdata", mlog[0].wd, 32'hDEADBEEF);
        chk("sw latency", last_lat, 2);

        // sb 0x103 then lbu/lb
        do_req(32'h103, 2'b00, 1, 0, 32'h000000AB);
        chk("sb cycles", mlog.size(), 1);
        chk("sb be", {28'b0, mlog[0].be}, 32'h8);
        chk("sb wdata", mlog[0].wd, 32'hAB000000);
        do_req(32'h103, 2'b00, 0, 1, 0);
        chk("lbu", last_rdata, 32'h000000AB);
        do_req(32'h103, 2'b00, 0, 0, 0);
        chk("lb", last_rdata, 32'hFFFFFFAB);

        // split sw 0x102 and lw back
        do_req(32'h102, 2'b10, 1, 0, 32'h11223344);
        chk("split sw cycles", mlog.size(), 2);
        chk("split lo addr", {2'b0, mlog[0].a}, 32'h40);
        chk("split lo be", {28'b0, mlog[0].be}, 32'hC);
        chk("split lo wdata", mlog[0].wd, 32'h33440000);
        chk("split hi addr", {2'b0, mlog[1].a}, 32'h41);
        chk("split hi be", {28'b0, mlog[1].be}, 32'h3);
        chk("split hi wdata", mlog[1].wd, 32'h00001122);
        do_req(32'h102, 2'b10, 0, 0, 0);
        chk("split lw", last_rdata, 32'h11223344);
        chk("split lw latency", last_lat, 3);

        // split halfword loads with sign bit set
        do_req(32'h103, 2'b00, 1, 0, 32'h80);
        do_req(32'h104, 2'b00, 1, 0, 32'hFF);
        do_req(32'h103, 2'b01, 0, 0, 0);
        chk("lh split", last_rdata, 32'hFFFFFF80);
        do_req(32'h103, 2'b01, 0, 1, 0);
        chk("lhu split", last_rdata, 32'h0000FF80);

        // word address wrap
        do_req(32'hFFFFFFFC, 2'b10, 1, 0, 32'h02010000);
        do_req(32'h00000000, 2'b10, 1, 0, 32'h00000403);
        do_req(32'hFFFFFFFE, 2'b10, 0, 0, 0);
        chk("wrap lo addr", {2'b0, mlog[0].a}, 32'h3FFFFFFF);
        chk("wrap hi addr", {2'b0, mlog[1].a}, 32'h0);
        chk("wrap lw", last_rdata, 32'h04030201);

        // every offset/size load in one word pair
        for (int o = 0; o < 4; o++)
            for (int s = 0; s < 3; s++)
                do_req(32'h100 + 32'(o), 2'(s), 0, o[0], 0);

        // illegal size, load and store
        do_req(32'h100, 2'b11, 0, 0, 0);
        chk("size11 err", {31'b0, last_err}, 1);
        chk("size11 latency", last_lat, 1);
        chk("size11 no mem", mlog.size(), 0);
        do_req(32'h100, 2'b11, 1, 0, 32'h12345678);
        chk("size11 st no mem", mlog.size(), 0);

        // misalign rejection on the second instance
        @(negedge clk);
        req_addr = 32'h103; req_size = 2'b01; req_we = 1; req_wdata = 32'hBEEF; valid2 = 1;
        @(negedge clk);
        valid2 = 0;
        chk("rej resp", {29'b0, resp_valid2, resp_err2, ready2}, 32'b110);
        chk("rej strobes", {30'b0, mem_we2, mem_re2}, 0);
        chk("rej rdata", resp_rdata2, 0);
        @(negedge clk);
        chk("rej back idle", {30'b0, ready2, resp_valid2}, 32'b10);
        req_addr = 32'h102; valid2 = 1;
        @(negedge clk);
        valid2 = 0;
        chk("aligned2 addr", {2'b0, mem_addr2}, 32'h40);
        chk("aligned2 be", {28'b0, mem_be2}, 32'hC);
        chk("aligned2 wdata", mem_wdata2, 32'hBEEF0000);
        @(negedge clk);
        chk("aligned2 resp", {30'b0, resp_valid2, resp_err2}, 32'b10);

        // reset during HI of a split store
        @(negedge clk);
        req_addr = 32'h202; req_size = 2'b10; req_we = 1; req_unsigned = 0;
        req_wdata = 32'hCAFEF00D; req_valid = 1;
        model_req(32'h202, 2'b10, 1, 0, 32'hCAFEF00D);
        @(negedge clk);
        req_valid = 0;
        @(negedge clk);
        chk("in HI be", {28'b0, mem_be}, 32'h3);
        reset = 1;
        exp_q.delete();
        @(negedge clk);
        chk("post-reset ready", {31'b0, req_ready}, 1);
        chk("post-reset strobes", {29'b0, mem_we, mem_re, resp_valid}, 0);
        reset = 0;

        // request held valid across a busy period: accepted once, in IDLE
        @(negedge clk);
        acc0 = acc_cnt;
        req_addr = 32'h100; req_size = 2'b10; req_we = 0; req_unsigned = 0; req_wdata = 0;
        req_valid = 1;
        model_req(32'h100, 2'b10, 0, 0, 0);
        @(negedge clk);
        req_addr = 32'h101; req_size = 2'b00; req_unsigned = 1; req_wdata = 32'h55;
        exp_q.push_back(idle_obs());
        model_req(32'h101, 2'b00, 0, 1, 32'h55);
        repeat (3) @(negedge clk);
        req_valid = 0;
        drain();
        chk("held lbu", last_rdata, 32'h000000BE);
        chk("held accepts", acc_cnt - acc0, 2);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
